// File: rtl/cpu_bus_mem.sv
// rtl/cpu_bus_mem.sv - cpu bus responder: word RAM plus MMIO console TX FIFO and cycle counter
module cpu_bus_mem #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) * 33'd4;

    logic [31:0] mem [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic          overflow;
    logic [31:0]   cycle_cnt;

    logic          is_read, is_write;
    logic          in_ram, mmio_hit;
    logic [1:0]    byte_sel, mmio_reg;
    logic [AW-1:0] word_idx;
    logic [3:0]    ram_lanes;
    logic [31:0]   wdata_sh, rdata_sh, rd_next;
    logic          fifo_full, fifo_empty;
    logic          push_req, push_ok, pop, ovf_set, ovf_clr;

    assign is_read  = enable_i && (wstrb_i == 4'b0000);
    assign is_write = enable_i && (wstrb_i != 4'b0000);
    assign in_ram   = ({1'b0, addr_i} < RAM_LIMIT);
    assign mmio_hit = (addr_i[31:4] == 28'h8000000);
    assign byte_sel = addr_i[1:0];
    assign mmio_reg = addr_i[3:2];
    assign word_idx = addr_i[AW+1:2];

    // Strobes shifted past lane 3 fall off the 4-bit result and are dropped.
    assign ram_lanes = wstrb_i << byte_sel;
    assign wdata_sh  = wvalue_i << {byte_sel, 3'b000};
    assign rdata_sh  = mem[word_idx] >> {byte_sel, 3'b000};

    assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = tx_valid_o ? fifo_mem[rd_ptr] : 8'h00;

    assign pop      = tx_valid_o && tx_ready_i;
    assign push_req = is_write && mmio_hit && (mmio_reg == 2'd0) && wstrb_i[0];
    assign push_ok  = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = is_write && mmio_hit && (mmio_reg == 2'd1) && wstrb_i[0] && wvalue_i[2];

    always_comb begin
        rd_next = 32'h0;
        if (mmio_hit) begin
            case (mmio_reg)
                2'd1:    rd_next = {29'b0, overflow, fifo_empty, fifo_full};
                2'd2:    rd_next = cycle_cnt;
                default: rd_next = 32'h0;
            endcase
        end else if (in_ram) begin
            rd_next = rdata_sh;
        end
    end

    always_ff @(posedge clk_i) begin
        if (is_write && in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_lanes[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= wvalue_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalue_o   <= 32'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            cycle_cnt  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (is_read) rvalue_o <= rd_next;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // A same-edge overflow outranks a software clear.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cpu_bus_mem.sv
// tb/tb_cpu_bus_mem.sv - self-checking bench for cpu_bus_mem
module tb_cpu_bus_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  wstrb;
    logic [31:0] addr, wvalue, rvalue;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int checks = 0;
    int failures = 0;
    logic [7:0]  got[$];
    logic [31:0] rd, c0, c1;

    localparam logic [31:0] CON_DATA = 32'h8000_0000;
    localparam logic [31:0] CON_STAT = 32'h8000_0004;
    localparam logic [31:0] CYCLE    = 32'h8000_0008;

    cpu_bus_mem #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .INIT_FILE("")) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .wstrb_i(wstrb), .addr_i(addr),
        .wvalue_i(wvalue), .rvalue_o(rvalue), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [31:0] a;
        logic [3:0]  strb;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tasks are entered just after a falling edge and return just after one.
    task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        enable = 1'b1; wstrb = s; addr = a; wvalue = d;
        @(negedge clk);
        enable = 1'b0; wstrb = 4'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        enable = 1'b1; wstrb = 4'b0; addr = a;
        @(negedge clk);
        d = rvalue;
        enable = 1'b0;
    endtask

    task automatic drain(input int cycles);
        got.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (tx_valid) got.push_back(tx_data);
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; wstrb = 4'b0; addr = 32'h0; wvalue = 32'h0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rvalue", rvalue, 32'h0);
        check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("reset_tx_data", {24'b0, tx_data}, 32'h0);
        rst = 1'b0;

        // Test 1: rvalue must not change before the read edge.
        bus_write(32'h10, 4'b1111, 32'h1122_3344);
        check("t1_before_read", rvalue, 32'h0);
        bus_read(32'h10, rd);
        check("t1_lw_one_cycle", rd, 32'h1122_3344);

        vecs = '{
            '{1'b0, 32'h0000_0013, 4'b0001, 32'h0000_00AB, 32'h0},
            '{1'b1, 32'h0000_0010, 4'b0000, 32'h0,         32'hAB22_3344},
            '{1'b1, 32'h0000_0013, 4'b0000, 32'h0,         32'h0000_00AB},
            '{1'b0, 32'h0000_0012, 4'b0011, 32'h0000_BEEF, 32'h0},
            '{1'b1, 32'h0000_0010, 4'b0000, 32'h0,         32'hBEEF_3344},
            '{1'b1, 32'h0000_0012, 4'b0000, 32'h0,         32'h0000_BEEF},
            '{1'b0, 32'h0000_0011, 4'b1111, 32'hCAFE_BABE, 32'h0},
            '{1'b1, 32'h0000_0010, 4'b0000, 32'h0,         32'hFEBA_BE44},
            '{1'b1, 32'h0000_0011, 4'b0000, 32'h0,         32'h00FE_BABE},
            '{1'b0, 32'h0000_0000, 4'b1111, 32'h5566_7788, 32'h0},
            '{1'b1, 32'h4000_0000, 4'b0000, 32'h0,         32'h0},
            '{1'b0, 32'h4000_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0},
            '{1'b0, 32'h0000_1000, 4'b1111, 32'h0BAD_F00D, 32'h0},
            '{1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h5566_7788},
            '{1'b1, 32'h0000_1000, 4'b0000, 32'h0,         32'h0},
            '{1'b1, 32'h0000_0FFC, 4'b0000, 32'h0,         32'h0},
            '{1'b1, 32'h8000_000C, 4'b0000, 32'h0,         32'h0},
            '{1'b1, CON_DATA,      4'b0000, 32'h0,         32'h0},
            '{1'b1, CON_STAT,      4'b0000, 32'h0,         32'h2}
        };
        bus_write(32'hFFC, 4'b1111, 32'h0);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_read) begin
                bus_read(vecs[i].a, rd);
                check($sformatf("vec%0d_rd_%h", i, vecs[i].a), rd, vecs[i].exp);
            end else begin
                bus_write(vecs[i].a, vecs[i].strb, vecs[i].d);
            end
        end

        // Test 3: fill with consumer stalled, then overflow.
        for (int i = 0; i < 8; i++) bus_write(CON_DATA, 4'b0001, 32'h41 + i);
        bus_read(CON_STAT, rd);
        check("t3_stat_full", rd, 32'h1);
        check("t3_head_stable", {24'b0, tx_data}, 32'h41);
        bus_write(CON_DATA, 4'b0001, 32'h49);
        bus_read(CON_STAT, rd);
        check("t3_stat_overflow", rd, 32'h5);
        drain(12);
        check("t3_drain_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("t3_byte%0d", i), {24'b0, got[i]}, 32'h41 + i);
        bus_read(CON_STAT, rd);
        check("t3_stat_empty_ovf", rd, 32'h6);
        bus_write(CON_STAT, 4'b0001, 32'h4);
        bus_read(CON_STAT, rd);
        check("t3_stat_cleared", rd, 32'h2);

        // Test 4: push into a full FIFO on the same edge as a pop.
        for (int i = 0; i < 8; i++) bus_write(CON_DATA, 4'b0001, 32'h30 + i);
        check("t4_head", {24'b0, tx_data}, 32'h30);
        tx_ready = 1'b1;
        bus_write(CON_DATA, 4'b0001, 32'h5A);
        tx_ready = 1'b0;
        bus_read(CON_STAT, rd);
        check("t4_stat_no_ovf", rd, 32'h1);
        drain(12);
        check("t4_drain_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++)
            check($sformatf("t4_byte%0d", i), {24'b0, got[i]}, (i == 7) ? 32'h5A : 32'h31 + i);

        // Test 5: cycle counter spacing and reset.
        bus_read(CYCLE, c0);
        repeat (9) @(negedge clk);
        bus_read(CYCLE, c1);
        check("t5_cycle_delta", c1 - c0, 32'd10);
        bus_write(CON_DATA, 4'b0001, 32'h77);
        check("t5_pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_rvalue", rvalue, 32'h0);
        check("t5_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("t5_rst_tx_data", {24'b0, tx_data}, 32'h0);
        rst = 1'b0;
        bus_read(CYCLE, rd);
        check("t5_cycle_small", {31'b0, rd < 32'd4}, 32'h1);
        bus_read(CON_STAT, rd);
        check("t5_stat_after_rst", rd, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
